// File: rtl/sm3_stream_hash.sv
`default_nettype none
// =============================================================================
// Module   : sm3_stream_hash (with iterative sm3_CF compression core)
// Brief    : Streaming SM3 hash over 512-bit blocks with internal padding.
//            Optional SM3_IV_LOAD_EN adds iv_load/iv_in for chain resumption.
// Revision : 1.0
// =============================================================================

module sm3_CF (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         cf_start,
   input  logic [255:0] v_in,
   input  logic [511:0] b_in,
   output logic         cf_end,
   output logic [255:0] v_out
);
   localparam logic [1:0] S_IDLE = 2'd0, S_RUN = 2'd1, S_END = 2'd2;

   logic [1:0]  r_st, w_st_next;
   logic [5:0]  r_j;
   logic [31:0] r_w [16];
   logic [31:0] r_a, r_b, r_c, r_d, r_e, r_f, r_g, r_h;
   logic [255:0] r_v;
   logic [31:0] w_a12, w_tj, w_ss1, w_ss2, w_ff, w_gg, w_tt1, w_tt2, w_wn;

   function automatic logic [31:0] rotl(input logic [31:0] x, input logic [4:0] n);
      return (x << n) | (x >> (6'd32 - {1'b0, n}));
   endfunction

   always_ff @(posedge clk) begin
      if (!rst_n) r_st <= S_IDLE;
      else        r_st <= w_st_next;
   end

   always_comb begin
      w_st_next = r_st;
      case (r_st)
         S_IDLE:  if (cf_start) w_st_next = S_RUN;
         S_RUN:   if (r_j == 6'd63) w_st_next = S_END;
         S_END:   w_st_next = S_IDLE;
         default: w_st_next = S_IDLE;
      endcase
   end

   always_comb begin
      cf_end = (r_st == S_END);
      v_out  = {r_a, r_b, r_c, r_d, r_e, r_f, r_g, r_h} ^ r_v;
   end

   // One round per cycle; r_w is a sliding window holding W[j..j+15]
   always_comb begin
      w_a12 = rotl(r_a, 5'd12);
      w_tj  = (r_j < 6'd16) ? 32'h79cc4519 : 32'h7a879d8a;
      w_ss1 = rotl(w_a12 + r_e + rotl(w_tj, r_j[4:0]), 5'd7);
      w_ss2 = w_ss1 ^ w_a12;
      w_ff  = (r_j < 6'd16) ? (r_a ^ r_b ^ r_c) : ((r_a & r_b) | (r_a & r_c) | (r_b & r_c));
      w_gg  = (r_j < 6'd16) ? (r_e ^ r_f ^ r_g) : ((r_e & r_f) | (~r_e & r_g));
      w_tt1 = w_ff + r_d + w_ss2 + (r_w[0] ^ r_w[4]);
      w_tt2 = w_gg + r_h + w_ss1 + r_w[0];
      w_wn  = r_w[0] ^ r_w[7] ^ rotl(r_w[13], 5'd15);
      w_wn  = w_wn ^ rotl(w_wn, 5'd15) ^ rotl(w_wn, 5'd23) ^ rotl(r_w[3], 5'd7) ^ r_w[10];
   end

   always_ff @(posedge clk) begin
      if (r_st == S_IDLE && cf_start) begin
         {r_a, r_b, r_c, r_d, r_e, r_f, r_g, r_h} <= v_in;
         r_v <= v_in;
         r_j <= 6'd0;
         for (int i = 0; i < 16; i++) r_w[i] <= b_in[511-32*i -: 32];
      end else if (r_st == S_RUN) begin
         r_j <= r_j + 6'd1;
         r_d <= r_c;
         r_c <= rotl(r_b, 5'd9);
         r_b <= r_a;
         r_a <= w_tt1;
         r_h <= r_g;
         r_g <= rotl(r_f, 5'd19);
         r_f <= r_e;
         r_e <= w_tt2 ^ rotl(w_tt2, 5'd9) ^ rotl(w_tt2, 5'd17);
         for (int i = 0; i < 15; i++) r_w[i] <= r_w[i+1];
         r_w[15] <= w_wn;
      end
   end
endmodule

module sm3_stream_hash #(
   parameter int LEN_W = 64
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [LEN_W-1:0] msg_bits,
   input  logic             blk_valid,
   output logic             blk_ready,
   input  logic [511:0]     blk_data,
   output logic             busy,
   output logic             done,
   output logic [255:0]     digest
`ifdef SM3_IV_LOAD_EN
   ,
   input  logic             iv_load,
   input  logic [255:0]     iv_in
`endif
);
   localparam logic [255:0] C_IV =
      256'h7380166f4914b2b9172442d7da8a0600a96f30bc163138aae38dee4db0fb0e4e;
   localparam logic [2:0] ST_IDLE = 3'd0, ST_WAIT = 3'd1, ST_RUN = 3'd2,
                          ST_PAD  = 3'd3, ST_FIN  = 3'd4;

   logic [2:0]   r_state, w_next;
   logic [63:0]  r_len;
   logic [55:0]  r_cnt, w_cnt_inc, w_nin;
   logic [8:0]   w_r;
   logic         w_pad_extra;
   logic [255:0] r_chain, r_digest, w_cf_out, w_iv_init;
   logic [511:0] r_blk, w_keep, w_last_blk;
   logic         w_cf_start, w_cf_end;

`ifdef SM3_IV_LOAD_EN
   assign w_iv_init = iv_load ? iv_in : C_IV;
`else
   assign w_iv_init = C_IV;
`endif

   assign w_r         = r_len[8:0];
   assign w_nin       = {1'b0, r_len[63:9]} + {55'd0, (w_r != 9'd0)};
   assign w_pad_extra = (w_r == 9'd0) || (w_r > 9'd447);
   assign w_cnt_inc   = r_cnt + 56'd1;
   assign digest      = r_digest;

   sm3_CF u_cf (
      .clk      (clk),
      .rst_n    (~reset),
      .cf_start (w_cf_start),
      .v_in     (r_chain),
      .b_in     (r_blk),
      .cf_end   (w_cf_end),
      .v_out    (w_cf_out)
   );

   always_ff @(posedge clk) begin
      if (reset) r_state <= ST_IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE: if (start) w_next = (msg_bits != '0) ? ST_WAIT : ST_PAD;
         ST_WAIT: if (blk_valid) w_next = ST_RUN;
         ST_RUN:  if (w_cf_end) begin
                     if (w_cnt_inc < w_nin)                      w_next = ST_WAIT;
                     else if (w_cnt_inc == w_nin && w_pad_extra) w_next = ST_PAD;
                     else                                        w_next = ST_FIN;
                  end
         ST_PAD:  w_next = ST_RUN;
         ST_FIN:  w_next = ST_IDLE;
         default: w_next = ST_IDLE;
      endcase
   end

   always_comb begin
      blk_ready  = (r_state == ST_WAIT);
      busy       = (r_state == ST_WAIT) || (r_state == ST_RUN) || (r_state == ST_PAD);
      done       = (r_state == ST_FIN);
      w_cf_start = (r_state == ST_RUN);
   end

   // Final partial block: keep r message bits, append the 1, clear the tail
   always_comb begin
      w_keep     = {512{1'b1}} << (10'd512 - {1'b0, w_r});
      w_last_blk = (blk_data & w_keep) | (512'd1 << (10'd511 - {1'b0, w_r}));
      if (w_r <= 9'd447) w_last_blk[63:0] = r_len;
      if (w_r == 9'd0)   w_last_blk = blk_data;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_len    <= '0;
         r_cnt    <= '0;
         r_chain  <= C_IV;
         r_blk    <= '0;
         r_digest <= '0;
      end else begin
         case (r_state)
            ST_IDLE: if (start) begin
                        r_len    <= 64'(msg_bits);
                        r_cnt    <= '0;
                        r_chain  <= w_iv_init;
                        r_digest <= '0;
                     end
            ST_WAIT: if (blk_valid) r_blk <= (w_cnt_inc == w_nin) ? w_last_blk : blk_data;
            ST_RUN:  if (w_cf_end) begin
                        r_chain <= w_cf_out;
                        r_cnt   <= w_cnt_inc;
                        if (w_next == ST_FIN) r_digest <= w_cf_out;
                     end
            ST_PAD:  r_blk <= {(w_r == 9'd0), 447'd0, r_len};
            default: ;
         endcase
      end
   end
endmodule
`default_nettype wire
